mont_exp_ctrl: RTL and testbench
================================

Name: mont_exp_ctrl

Overview:
Modular-exponentiation sequencer that sits directly upstream of the montgomery multiplier and drives its start/a/b → c/done handshake. It uses constant-time left-to-right square-and-multiply over a Montgomery-domain base. A final multiply-by-1 converts the result out of the Montgomery domain. The modulus N and the R^-1 factor belong to the multiplier; this block only sequences operands and captures results.

Parameters:
WIDTH, 32, operand/result width in bits; must match the multiplier operand width.
EXP_WIDTH, 16, exponent width in bits; number of square steps per run.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
x_mont  in  WIDTH  base in Montgomery domain (x·R mod N)
one_mont  in  WIDTH  R mod N (Montgomery-domain 1)
exponent  in  EXP_WIDTH  exponent e
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  WIDTH  multiplier operand a
mul_b  out  WIDTH  multiplier operand b
mul_c  in  WIDTH  multiplier result; valid when mul_done=1
mul_done  in  1  multiplier completion pulse
result  out  WIDTH  x^e mod N in the normal domain; held until the next run captures a new value
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is updated

Behaviour:
- Reset (async, rst=1): state=IDLE. Internal registers: acc=0, x_reg=0, e_reg=0, idx=0. Outputs: result=0, mul_a=0, mul_b=0, mul_start=0, done=0, busy=0. Reset asserted mid-run aborts the run immediately. A mul_done arriving after reset is released is ignored, because the state is IDLE.
- States: IDLE, SQ_REQ, SQ_WAIT, MU_REQ, MU_WAIT, OUT_REQ, OUT_WAIT, DONE.
- IDLE, on start=1:
  - latch x_reg<=x_mont, e_reg<=exponent, acc<=one_mont, idx<=EXP_WIDTH-1.
  - go to SQ_REQ.
  - start in any other state is ignored; no queuing.
- SQ_REQ: mul_start=1 for this cycle only, with mul_a=mul_b=acc. Go to SQ_WAIT.
- SQ_WAIT: wait for mul_done.
  - On mul_done: acc<=mul_c.
  - If e_reg[idx]=1, go to MU_REQ; otherwise take the next-bit step.
- MU_REQ: mul_start=1, mul_a=acc, mul_b=x_reg. Go to MU_WAIT.
- MU_WAIT: on mul_done, acc<=mul_c, then take the next-bit step.
- Next-bit step: if idx==0, go to OUT_REQ; otherwise idx<=idx-1 and go to SQ_REQ.
- OUT_REQ: mul_start=1, mul_a=acc, mul_b=1 (zero-extended to WIDTH). Go to OUT_WAIT.
- OUT_WAIT: on mul_done, result<=mul_c and go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. busy drops in the cycle that follows DONE.
- Operand stability: mul_a and mul_b are registered. They are updated in the cycle before each REQ state and held constant through the matching WAIT state.
- Spurious mul_done in IDLE, any REQ state, or DONE is ignored. Only WAIT states consume it.
- Multiplication count per run: EXP_WIDTH + popcount(e) + 1. No leading-zero skip; squarings are constant-time by design.
- Latency: with a multiplier that pulses mul_done L cycles after mul_start, each multiplication costs L+1 cycles. done rises 1 cycle after the final accept.
- Edge cases:
  - e=0: EXP_WIDTH squarings of one_mont, then conversion, so result=1.
  - All inputs are captured at start; later input changes have no effect on the run in progress.
- Arithmetic: no arithmetic in this block. Widths are passed through unchanged.

Test Plan:
Bench multiplier model computes a·b·R^-1 mod N with programmable latency L. Test configuration: WIDTH=8, EXP_WIDTH=4, N=13, R=256 (R mod 13 = 9), x=2 so x_mont=5.
1. e=5, L=3 → result=6 (32 mod 13), exactly 7 mul_start pulses, done high for 1 cycle, busy low afterwards.
2. e=0, L=1 → result=1, 5 mul_start pulses; e=15 → result=8 (2^15 mod 13), 9 pulses.
3. Second start pulse during a run, plus input changes mid-run → ignored; result still 6 for e=5.
4. Spurious mul_done in SQ_REQ and in IDLE → no state advance, pulse counts unchanged; mul_a and mul_b stable throughout each WAIT state.
5. rst asserted mid MU_WAIT, asynchronously between clock edges → outputs 0 immediately. A late mul_done is ignored. A subsequent start with e=5 yields result=6.
6. Back-to-back runs: start in the cycle after done with e=3 → result=8 (2^3 mod 13); the previous result is held until overwritten.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: constant-time left-to-right square-and-multiply sequencer for a Montgomery multiplier
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             run request, sampled only while idle
//   x_mont, one_mont  base and 1 in the Montgomery domain, captured at start
//   exponent          exponent e, captured at start
//   mul_start/a/b     registered request and operands to the multiplier
//   mul_c/mul_done    multiplier result and its completion pulse
//   result            x^e mod N in the normal domain, held between runs
//   busy, done        run in progress, one-cycle completion pulse
module mont_exp_ctrl #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x_mont,
  input  logic [WIDTH-1:0]     one_mont,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [WIDTH-1:0]     mul_c,
  input  logic                 mul_done,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, SQ_REQ, SQ_WAIT, MU_REQ, MU_WAIT, OUT_REQ, OUT_WAIT, DONE} state_t;
  state_t               r_state;
  logic [WIDTH-1:0]     r_acc, r_x, r_mul_a, r_mul_b, r_result;
  logic [EXP_WIDTH-1:0] r_e;
  logic [IW-1:0]        r_idx;
  logic                 r_mul_start, r_done, r_busy;
  logic                 w_bit, w_next;
  assign w_bit  = r_e[r_idx];
  // a finished square with a clear bit, or a finished multiply, both move to the next exponent bit
  assign w_next = mul_done && (r_state == MU_WAIT || (r_state == SQ_WAIT && !w_bit));
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign result    = r_result;
  assign busy      = r_busy;
  assign done      = r_done;
  // operands are loaded on the edge entering each REQ state, so they are stable across the whole WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_x         <= '0;
      r_e         <= '0;
      r_idx       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
      r_result    <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_x         <= x_mont;
          r_e         <= exponent;
          r_acc       <= one_mont;
          r_idx       <= IW'(EXP_WIDTH - 1);
          r_mul_a     <= one_mont;
          r_mul_b     <= one_mont;
          r_mul_start <= 1'b1;
          r_busy      <= 1'b1;
          r_state     <= SQ_REQ;
        end
        SQ_REQ: r_state <= SQ_WAIT;
        SQ_WAIT: if (mul_done) begin
          r_acc <= mul_c;
          if (w_bit) begin
            r_mul_a     <= mul_c;
            r_mul_b     <= r_x;
            r_mul_start <= 1'b1;
            r_state     <= MU_REQ;
          end
        end
        MU_REQ: r_state <= MU_WAIT;
        MU_WAIT: if (mul_done) r_acc <= mul_c;
        OUT_REQ: r_state <= OUT_WAIT;
        OUT_WAIT: if (mul_done) begin
          r_result <= mul_c;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_next) begin
        r_mul_a     <= mul_c;
        r_mul_start <= 1'b1;
        if (r_idx == '0) begin
          r_mul_b <= WIDTH'(1);
          r_state <= OUT_REQ;
        end else begin
          r_idx   <= r_idx - 1'b1;
          r_mul_b <= mul_c;
          r_state <= SQ_REQ;
        end
      end
    end
  end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb_mont_exp_ctrl: directed bench with a mod-13 Montgomery multiplier model (R=256, R^-1 mod 13 = 3)
module tb_mont_exp_ctrl;
  logic       clk, rst, start, mul_start, mul_done, busy, done;
  logic [7:0] x_mont, one_mont, mul_a, mul_b, mul_c, result;
  logic [3:0] exponent;
  logic       m_done, m_busy, inj, prev_start;
  logic [7:0] m_a, m_b;
  int         lat, m_cnt, pulses, multi, stab_err, hold_err;
  int         n_chk, n_fail;

  mont_exp_ctrl #(.WIDTH(8), .EXP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x_mont(x_mont), .one_mont(one_mont),
    .exponent(exponent), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c(mul_c), .mul_done(mul_done), .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mm(input logic [7:0] a, input logic [7:0] b);
    return 8'((32'(a) * 32'(b) * 32'd3) % 32'd13);
  endfunction

  assign mul_done = m_done | inj;

  initial begin
    m_done = 1'b0; m_busy = 1'b0; m_cnt = 0; mul_c = '0; m_a = '0; m_b = '0;
    pulses = 0; multi = 0; stab_err = 0; prev_start = 1'b0;
  end

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (m_done) m_busy <= 1'b0;
    if (mul_start) begin
      m_a <= mul_a; m_b <= mul_b; m_busy <= 1'b1;
      if (lat == 1) begin m_done <= 1'b1; mul_c <= mm(mul_a, mul_b); end
      else m_cnt <= lat - 1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin m_done <= 1'b1; mul_c <= mm(m_a, m_b); end
    end
  end

  always @(negedge clk) begin
    prev_start <= mul_start;
    if (mul_start) begin
      pulses <= pulses + 1;
      if (prev_start) multi <= multi + 1;
    end else if (m_busy && (mul_a !== m_a || mul_b !== m_b)) stab_err <= stab_err + 1;
  end

  task automatic run(input logic [3:0] e, input int l, input bit disturb, input bit spur,
                     output int cyc, output int np);
    int base;
    logic [7:0] prev;
    base = pulses; lat = l; exponent = e; prev = result;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    if (spur) inj = 1'b1;
    while (done !== 1'b1 && cyc < 500) begin
      if (result !== prev) hold_err++;
      @(negedge clk);
      cyc++;
      inj = 1'b0;
      if (disturb && cyc == 5) begin start = 1'b1; x_mont = 8'd7; one_mont = 8'd3; exponent = 4'd15; end
      if (disturb && cyc == 6) start = 1'b0;
    end
    np = pulses - base;
    x_mont = 8'd5; one_mont = 8'd9;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_chk++; if (result !== 8'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
    n_chk++; if (mul_start !== 1'b0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
      n_fail++; $display("FAIL reset_mul: got start=%0b a=%0d b=%0d expected 0 0 0", mul_start, mul_a, mul_b);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, np;
    run(4'd5, 3, 1'b0, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd6) begin n_fail++; $display("FAIL basic_result: got %0d expected 6", result); end
    n_chk++; if (np != 7) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 7", np); end
    n_chk++; if (cyc != 29) begin n_fail++; $display("FAIL basic_latency: got %0d expected 29", cyc); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_done: got %0b expected 1", busy); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b expected 0", done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0b expected 0", busy); end
    n_chk++; if (multi != 0) begin n_fail++; $display("FAIL basic_start_width: got %0d expected 0", multi); end
  endtask

  task automatic test_edges;
    int cyc, np;
    run(4'd0, 1, 1'b0, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd1) begin n_fail++; $display("FAIL e0_result: got %0d expected 1", result); end
    n_chk++; if (np != 5) begin n_fail++; $display("FAIL e0_pulses: got %0d expected 5", np); end
    n_chk++; if (cyc != 11) begin n_fail++; $display("FAIL e0_latency: got %0d expected 11", cyc); end
    @(negedge clk);
    run(4'd15, 1, 1'b0, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd8) begin n_fail++; $display("FAIL e15_result: got %0d expected 8", result); end
    n_chk++; if (np != 9) begin n_fail++; $display("FAIL e15_pulses: got %0d expected 9", np); end
    n_chk++; if (cyc != 19) begin n_fail++; $display("FAIL e15_latency: got %0d expected 19", cyc); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int cyc, np;
    run(4'd5, 3, 1'b1, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd6) begin n_fail++; $display("FAIL ignore_result: got %0d expected 6", result); end
    n_chk++; if (np != 7) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 7", np); end
    n_chk++; if (cyc != 29) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 29", cyc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious;
    int cyc, np, base;
    base = pulses;
    inj = 1'b1;
    @(negedge clk) inj = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL spur_idle_state: got busy=%0b done=%0b expected 0 0", busy, done); end
    n_chk++; if (pulses != base) begin n_fail++; $display("FAIL spur_idle_pulses: got %0d expected %0d", pulses, base); end
    n_chk++; if (result !== 8'd6) begin n_fail++; $display("FAIL spur_idle_result: got %0d expected 6", result); end
    run(4'd5, 3, 1'b0, 1'b1, cyc, np);
    n_chk++; if (result !== 8'd6) begin n_fail++; $display("FAIL spur_req_result: got %0d expected 6", result); end
    n_chk++; if (np != 7) begin n_fail++; $display("FAIL spur_req_pulses: got %0d expected 7", np); end
    n_chk++; if (cyc != 29) begin n_fail++; $display("FAIL spur_req_latency: got %0d expected 29", cyc); end
    n_chk++; if (stab_err != 0) begin n_fail++; $display("FAIL operand_stability: got %0d violations expected 0", stab_err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int k, g, cyc, np;
    lat = 3; exponent = 4'd5;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = mul_start ? 1 : 0; g = 0;
    while (k < 3 && g < 200) begin
      @(negedge clk); g++;
      if (mul_start) k++;
    end
    n_chk++; if (k != 3) begin n_fail++; $display("FAIL rstmid_reach: got %0d pulses expected 3", k); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || result !== 8'd0) begin n_fail++; $display("FAIL rstmid_async: got busy=%0b result=%0d expected 0 0", busy, result); end
    n_chk++; if (mul_a !== 8'd0 || mul_b !== 8'd0 || mul_start !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_mul: got a=%0d b=%0d start=%0b done=%0b expected 0", mul_a, mul_b, mul_start, done);
    end
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || result !== 8'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_late_done: got busy=%0b result=%0d done=%0b expected 0 0 0", busy, result, done);
    end
    run(4'd5, 3, 1'b0, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd6) begin n_fail++; $display("FAIL rstmid_rerun: got %0d expected 6", result); end
    n_chk++; if (np != 7) begin n_fail++; $display("FAIL rstmid_pulses: got %0d expected 7", np); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc, np;
    run(4'd5, 3, 1'b0, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd6) begin n_fail++; $display("FAIL b2b_first: got %0d expected 6", result); end
    hold_err = 0;
    run(4'd3, 3, 1'b0, 1'b0, cyc, np);
    n_chk++; if (result !== 8'd8) begin n_fail++; $display("FAIL b2b_second: got %0d expected 8", result); end
    n_chk++; if (cyc != 29) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 29", cyc); end
    n_chk++; if (np != 7) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 7", np); end
    n_chk++; if (hold_err != 0) begin n_fail++; $display("FAIL b2b_hold: got %0d changes expected 0", hold_err); end
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; inj = 1'b0;
    x_mont = 8'd5; one_mont = 8'd9; exponent = 4'd0; lat = 3;
    n_chk = 0; n_fail = 0; hold_err = 0;
    test_reset;
    test_basic;
    test_edges;
    test_ignore_start;
    test_spurious;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
